join_any_ctrl: RTL and testbench

JOIN_ANY_CTRL -- requirements
Module: join_any

---
 rtl/join_any_pkg.sv | 17 +
 rtl/ja_task_timer.sv | 38 +++
 rtl/join_any_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_join_any_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/join_any_pkg.sv
// Shared constants and state encoding for the join_any controller.
package join_any_pkg;

  localparam int unsigned NUM_BR_DEF  = 3;
  localparam int unsigned NUM_SEQ_DEF = 2;
  localparam int unsigned DLY_W_DEF   = 8;
  localparam int unsigned TIME_W_DEF  = 16;
  localparam int unsigned ID_W        = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FORK  = 2'd1,
    S_SEQ   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/ja_task_timer.sv
// Delay timer: i_load clears it, i_en marks the origin cycle, o_done_c fires
// i_dly cycles later (same cycle when i_dly is 0), i_kill abandons the count.
module ja_task_timer #(
  parameter int unsigned DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic             i_kill,
  input  logic [DLY_W-1:0] i_dly,
  output logic             o_done_c
);

  logic             r_run;
  logic [DLY_W-1:0] r_cnt;

  // Completion is visible in the cycle it happens so zero delays can chain.
  assign o_done_c = (i_en && (i_dly == '0)) || (r_run && (r_cnt == i_dly));

  // Elapsed-cycle counter; kill wins over a start in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (i_load || i_kill) begin
      r_run <= 1'b0;
      r_cnt <= '0;
    end else if (r_run) begin
      if (r_cnt == i_dly) r_run <= 1'b0;
      else                r_cnt <= r_cnt + DLY_W'(1);
    end else if (i_en && (i_dly != '0)) begin
      r_run <= 1'b1;
      r_cnt <= DLY_W'(1);
    end
  end

endmodule

// File: rtl/join_any_ctrl.sv
// Fork/join_any controller: parallel branches, a sequential post-join chain,
// auto-disable of stragglers and an ordered completion event stream.
module join_any_ctrl
  import join_any_pkg::*;
#(
  parameter int unsigned NUM_BR  = NUM_BR_DEF,
  parameter int unsigned NUM_SEQ = NUM_SEQ_DEF,
  parameter int unsigned DLY_W   = DLY_W_DEF,
  parameter int unsigned TIME_W  = TIME_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_BR*DLY_W-1:0]  br_delay,
  input  logic [NUM_SEQ*DLY_W-1:0] seq_delay,
  input  logic                     kill,
  output logic                     busy,
  output logic                     any_done,
  output logic                     evt_valid,
  output logic [ID_W-1:0]          evt_id,
  output logic [DLY_W-1:0]         evt_delay,
  output logic [TIME_W-1:0]        evt_time,
  output logic [NUM_BR-1:0]        killed_mask,
  output logic                     done
);

  localparam int unsigned NUM_T = NUM_BR + NUM_SEQ;

  state_e              r_state, w_state_nxt;
  logic [TIME_W-1:0]   r_ts;
  logic [DLY_W-1:0]    r_dly   [NUM_T];
  logic [TIME_W-1:0]   r_ctime [NUM_T];
  logic [NUM_T-1:0]    r_pend;
  logic [NUM_BR-1:0]   r_fin;
  logic [NUM_BR-1:0]   r_killed;
  logic                r_busy, r_any_done, r_evt_valid, r_done;
  logic [ID_W-1:0]     r_evt_id;
  logic [DLY_W-1:0]    r_evt_delay;
  logic [TIME_W-1:0]   r_evt_time;

  logic                w_accept, w_br_go, w_first, w_last_seq, w_disable;
  logic [NUM_BR-1:0]   w_br_done;
  logic [NUM_SEQ-1:0]  w_seq_done;
  logic [NUM_T-1:0]    w_new, w_cand, w_sel;
  logic                w_sel_vld;
  logic [ID_W-1:0]     w_sel_id;
  logic [DLY_W-1:0]    w_sel_dly;
  logic [TIME_W-1:0]   w_sel_time;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_br_go    = (r_state == S_FORK) && (r_ts == '0);
  assign w_first    = (r_state == S_FORK) && (|w_br_done);
  assign w_last_seq = w_seq_done[NUM_SEQ-1];
  assign w_disable  = (kill && ((r_state == S_FORK) || (r_state == S_SEQ))) || w_last_seq;
  assign w_new      = {w_seq_done, w_br_done};
  assign w_cand     = r_pend | w_new;

  // Branch timers all share the first FORK cycle as their origin.
  for (genvar b = 0; b < NUM_BR; b++) begin : g_br
    ja_task_timer #(.DLY_W(DLY_W)) u_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_accept),
      .i_en     (w_br_go),
      .i_kill   (w_disable),
      .i_dly    (r_dly[b]),
      .o_done_c (w_br_done[b])
    );
  end

  // Sequential chain: each task starts from its predecessor's completion.
  for (genvar s = 0; s < NUM_SEQ; s++) begin : g_seq
    logic w_go;
    logic w_dn;
    if (s == 0) begin : g_head
      assign w_go = w_first;
    end else begin : g_link
      assign w_go = g_seq[s-1].w_dn;
    end
    ja_task_timer #(.DLY_W(DLY_W)) u_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_accept),
      .i_en     (w_go),
      .i_kill   (1'b0),
      .i_dly    (r_dly[NUM_BR+s]),
      .o_done_c (w_dn)
    );
    assign w_seq_done[s] = w_dn;
  end

  // Pick the lowest pending-or-new id for emission this cycle.
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_id   = '0;
    w_sel_dly  = '0;
    w_sel_time = '0;
    w_sel      = '0;
    for (int j = NUM_T - 1; j >= 0; j--) begin
      if (w_cand[j]) begin
        w_sel_vld  = 1'b1;
        w_sel_id   = ID_W'(j + 1);
        w_sel_dly  = r_dly[j];
        w_sel_time = w_new[j] ? r_ts : r_ctime[j];
        w_sel      = '0;
        w_sel[j]   = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)        w_state_nxt = S_FORK;
      S_FORK:  if (w_first)      w_state_nxt = w_last_seq ? S_DRAIN : S_SEQ;
      S_SEQ:   if (w_last_seq)   w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_pend == '0) w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Run bookkeeping, timestamp, pending flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts        <= '0;
      r_pend      <= '0;
      r_fin       <= '0;
      r_killed    <= '0;
      r_busy      <= 1'b0;
      r_any_done  <= 1'b0;
      r_evt_valid <= 1'b0;
      r_done      <= 1'b0;
      r_evt_id    <= '0;
      r_evt_delay <= '0;
      r_evt_time  <= '0;
      for (int j = 0; j < NUM_T; j++) begin
        r_dly[j]   <= '0;
        r_ctime[j] <= '0;
      end
    end else begin
      r_any_done  <= w_first;
      r_evt_valid <= w_sel_vld;
      r_done      <= 1'b0;
      if (w_sel_vld) begin
        r_evt_id    <= w_sel_id;
        r_evt_delay <= w_sel_dly;
        r_evt_time  <= w_sel_time;
      end
      for (int j = 0; j < NUM_T; j++) begin
        if (w_new[j]) r_ctime[j] <= r_ts;
      end
      if (w_accept) begin
        r_busy   <= 1'b1;
        r_ts     <= '0;
        r_pend   <= '0;
        r_fin    <= '0;
        r_killed <= '0;
        for (int j = 0; j < NUM_BR; j++)  r_dly[j]        <= br_delay[j*DLY_W +: DLY_W];
        for (int j = 0; j < NUM_SEQ; j++) r_dly[NUM_BR+j] <= seq_delay[j*DLY_W +: DLY_W];
      end else begin
        if (r_busy && (r_ts != '1)) r_ts <= r_ts + TIME_W'(1);
        r_pend <= w_cand & ~w_sel;
        r_fin  <= r_fin | w_br_done;
        // A branch finishing in the disable cycle counts as completed.
        if (w_disable) r_killed <= r_killed | ~(r_fin | w_br_done);
        if ((r_state == S_DRAIN) && (r_pend == '0)) begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign any_done    = r_any_done;
  assign evt_valid   = r_evt_valid;
  assign evt_id      = r_evt_id;
  assign evt_delay   = r_evt_delay;
  assign evt_time    = r_evt_time;
  assign killed_mask = r_killed;
  assign done        = r_done;

endmodule

// File: tb/tb_join_any_ctrl.sv
// Directed bench for join_any_ctrl; cycle 0 is the first cycle after start.
module tb_join_any_ctrl;
  import join_any_pkg::*;

  localparam int unsigned NBR = 3;
  localparam int unsigned NSQ = 2;
  localparam int unsigned DW  = 8;
  localparam int unsigned TW  = 16;

  logic              clk, rst_n, start, kill;
  logic [NBR*DW-1:0] br_delay;
  logic [NSQ*DW-1:0] seq_delay;
  logic              busy, any_done, evt_valid, done;
  logic [ID_W-1:0]   evt_id;
  logic [DW-1:0]     evt_delay;
  logic [TW-1:0]     evt_time;
  logic [NBR-1:0]    killed_mask;

  int n_checks, n_errors;
  int ev_id[$], ev_dly[$], ev_tm[$], ev_cyc[$];
  int ad_cnt, ad_cyc, dn_cnt, dn_cyc;
  int cyc_vld [64];
  int cyc_id  [64];
  int cyc_tm  [64];
  int cyc_busy[64];

  join_any_ctrl #(.NUM_BR(NBR), .NUM_SEQ(NSQ), .DLY_W(DW), .TIME_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .br_delay    (br_delay),
    .seq_delay   (seq_delay),
    .kill        (kill),
    .busy        (busy),
    .any_done    (any_done),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_delay   (evt_delay),
    .evt_time    (evt_time),
    .killed_mask (killed_mask),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"},   int'(busy),        0);
    check_eq({tag, "_anydn"},  int'(any_done),    0);
    check_eq({tag, "_evtv"},   int'(evt_valid),   0);
    check_eq({tag, "_done"},   int'(done),        0);
    check_eq({tag, "_evtid"},  int'(evt_id),      0);
    check_eq({tag, "_evtdly"}, int'(evt_delay),   0);
    check_eq({tag, "_evttm"},  int'(evt_time),    0);
    check_eq({tag, "_killed"}, int'(killed_mask), 0);
  endtask

  task automatic check_evt(input string tag, input int k, input int id,
                           input int dly, input int tm, input int cy);
    if (k < ev_id.size()) begin
      check_eq({tag, "_id"},  ev_id[k],  id);
      check_eq({tag, "_dly"}, ev_dly[k], dly);
      check_eq({tag, "_tm"},  ev_tm[k],  tm);
      check_eq({tag, "_cyc"}, ev_cyc[k], cy);
    end else begin
      check_eq({tag, "_present"}, ev_id.size(), k + 1);
    end
  endtask

  // Called at a negedge; start is seen on the next posedge.
  task automatic launch(input logic [NBR*DW-1:0] br, input logic [NSQ*DW-1:0] sq);
    br_delay  = br;
    seq_delay = sq;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Sample cycles 0..n-1 at the negedge; optional kill / extra start pulses.
  task automatic run_for(input int n, input int kill_at, input int start_at);
    ev_id.delete(); ev_dly.delete(); ev_tm.delete(); ev_cyc.delete();
    ad_cnt = 0; ad_cyc = -1; dn_cnt = 0; dn_cyc = -1;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      if (evt_valid) begin
        ev_id.push_back(int'(evt_id));
        ev_dly.push_back(int'(evt_delay));
        ev_tm.push_back(int'(evt_time));
        ev_cyc.push_back(c);
      end
      if (any_done) begin
        if (ad_cnt == 0) ad_cyc = c;
        ad_cnt++;
      end
      if (done) begin
        if (dn_cnt == 0) dn_cyc = c;
        dn_cnt++;
      end
      if (c < 64) begin
        cyc_vld[c]  = int'(evt_valid);
        cyc_id[c]   = int'(evt_id);
        cyc_tm[c]   = int'(evt_time);
        cyc_busy[c] = int'(busy);
      end
      kill  = (c == kill_at);
      start = (c == start_at);
      if (c == start_at) begin
        br_delay  = '1;
        seq_delay = '0;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0;
    br_delay = '0; seq_delay = '0;
    repeat (3) @(negedge clk);
    check_zero("rst0");

    // Run A: ids 1..3 = 30,12,10; seq 5,1; started in first clock after release.
    rst_n = 1'b1;
    launch({8'd10, 8'd12, 8'd30}, {8'd1, 8'd5});
    run_for(21, -1, -1);
    check_eq("A_busy_c0", cyc_busy[0], 1);
    check_eq("A_nevt", ev_id.size(), 4);
    check_evt("A_e0", 0, 3, 10, 10, 11);
    check_evt("A_e1", 1, 2, 12, 12, 13);
    check_evt("A_e2", 2, 4,  5, 15, 16);
    check_evt("A_e3", 3, 5,  1, 16, 17);
    check_eq("A_ad_cnt", ad_cnt, 1);
    check_eq("A_ad_cyc", ad_cyc, 11);
    check_eq("A_killed", int'(killed_mask), 1);
    check_eq("A_done_cnt", dn_cnt, 1);
    check_eq("A_done_cyc", dn_cyc, 18);
    check_eq("A_busy_pre_done", cyc_busy[17], 1);
    check_eq("A_busy_at_done", cyc_busy[18], 0);
    check_eq("A_hold_vld", cyc_vld[12], 0);
    check_eq("A_hold_id", cyc_id[12], 3);
    check_eq("A_hold_tm", cyc_tm[12], 10);

    // Run B: simultaneous first completions 4,4,9; seq 1,1.
    @(negedge clk);
    launch({8'd9, 8'd4, 8'd4}, {8'd1, 8'd1});
    run_for(11, -1, -1);
    check_eq("B_nevt", ev_id.size(), 4);
    check_evt("B_e0", 0, 1, 4, 4, 5);
    check_evt("B_e1", 1, 2, 4, 4, 6);
    check_evt("B_e2", 2, 4, 1, 5, 7);
    check_evt("B_e3", 3, 5, 1, 6, 8);
    check_eq("B_ad_cnt", ad_cnt, 1);
    check_eq("B_ad_cyc", ad_cyc, 5);
    check_eq("B_killed", int'(killed_mask), 4);
    check_eq("B_done_cyc", dn_cyc, 9);

    // Run C: kill at cycle 5 before any branch finishes; only reset ends it.
    @(negedge clk);
    launch({8'd20, 8'd20, 8'd20}, {8'd3, 8'd3});
    run_for(40, 5, -1);
    check_eq("C_nevt", ev_id.size(), 0);
    check_eq("C_ad_cnt", ad_cnt, 0);
    check_eq("C_done_cnt", dn_cnt, 0);
    check_eq("C_killed", int'(killed_mask), 7);
    check_eq("C_busy", int'(busy), 1);
    check_eq("C_state", int'(dut.r_state), int'(S_FORK));
    rst_n = 1'b0;
    #1;
    check_zero("C_rst");

    // Run D: zero delays chain through the whole sequence in cycle 0.
    @(negedge clk);
    rst_n = 1'b1;
    launch({8'd50, 8'd50, 8'd0}, {8'd0, 8'd0});
    run_for(6, -1, -1);
    check_eq("D_busy_c0", cyc_busy[0], 1);
    check_eq("D_nevt", ev_id.size(), 3);
    check_evt("D_e0", 0, 1, 0, 0, 1);
    check_evt("D_e1", 1, 4, 0, 0, 2);
    check_evt("D_e2", 2, 5, 0, 0, 3);
    check_eq("D_ad_cyc", ad_cyc, 1);
    check_eq("D_killed", int'(killed_mask), 6);
    check_eq("D_done_cyc", dn_cyc, 4);

    // Run E: start while busy at cycle 8 is ignored; reset at cycle 11.
    @(negedge clk);
    launch({8'd10, 8'd12, 8'd30}, {8'd1, 8'd5});
    run_for(12, -1, 8);
    check_eq("E_nevt", ev_id.size(), 1);
    check_evt("E_e0", 0, 3, 10, 10, 11);
    check_eq("E_ad_cyc", ad_cyc, 11);
    check_eq("E_busy_c9", cyc_busy[9], 1);
    rst_n = 1'b0;
    #1;
    check_zero("E_rst");
    @(negedge clk);
    rst_n = 1'b1;
    launch({8'd9, 8'd4, 8'd4}, {8'd1, 8'd1});
    run_for(11, -1, -1);
    check_eq("E2_nevt", ev_id.size(), 4);
    check_evt("E2_e0", 0, 1, 4, 4, 5);
    check_evt("E2_e3", 3, 5, 1, 6, 8);
    check_eq("E2_done_cyc", dn_cyc, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
